// File: rtl/mdu_unit.sv
// mdu_unit -- multi-cycle multiply/divide unit with HI/LO result registers.
//
// Sits beside the ALU in EX. An op launched with Start computes its full
// 2*WIDTH result on the launch edge into a pending register pair; the unit
// then holds Busy high for a fixed latency and commits the pending pair to
// HI/LO on the last busy edge. mthi/mtlo write HI/LO directly while idle.
//
// Ports:
//   clk      in   1      rising-edge clock
//   reset    in   1      asynchronous active-low reset
//   Start    in   1      launch MDUOp this cycle
//   MDUOp    in   3      000 multu 001 mult 010 divu 011 div
//                        100 maddu 101 madd 110 msubu 111 msub
//   HIWrite  in   1      mthi: HI <= A
//   LOWrite  in   1      mtlo: LO <= A
//   A        in   WIDTH  rs operand
//   B        in   WIDTH  rt operand
//   Busy     out  1      registered, high while an op is in flight
//   HI       out  WIDTH  HI register
//   LO       out  WIDTH  LO register

// Protocol checker: the hazard unit must never issue an MD op or HI/LO move
// while the unit is busy. The unit ignores such requests; this flags them.
module mdu_unit_chk (
  input logic clk,
  input logic reset,
  input logic Busy,
  input logic Start,
  input logic HIWrite,
  input logic LOWrite
);

  a_no_issue_while_busy : assert property (
    @(posedge clk) disable iff (!reset)
      Busy |-> !(Start || HIWrite || LOWrite)
  ) else $warning("mdu_unit_chk: request while Busy is ignored");

endmodule

module mdu_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [2:0]       MDUOp,
  input  logic             HIWrite,
  input  logic             LOWrite,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0]    MUL_CNT = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0]    DIV_CNT = CW'(DIV_LAT - 1);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_W  = WIDTH'(0);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_r, state_s;
  logic [CW-1:0]      cnt_r, cnt_s;
  logic [WIDTH-1:0]   ph_r, ph_s, pl_r, pl_s;
  logic [WIDTH-1:0]   hi_r, hi_s, lo_r, lo_s;
  logic               busy_r;

  logic               is_div_s, sgn_s;
  logic [2*WIDTH-1:0] mul_a_s, mul_b_s, prod_s, acc_s, mres_s, dres_s, res_s;
  logic [WIDTH-1:0]   abs_a_s, abs_b_s, div_b_s, quo_s, rem_s, q_s, r_s;

  // Result datapath: full op result from the launch-edge operands and HI/LO.
  always_comb begin
    is_div_s = (MDUOp[2:1] == 2'b01);
    sgn_s    = MDUOp[0];
    acc_s    = {hi_r, lo_r};

    // Sign- or zero-extend, then the low 2*WIDTH bits of the unsigned
    // product equal the signed product modulo 2^(2*WIDTH).
    mul_a_s = sgn_s ? {{WIDTH{A[WIDTH-1]}}, A} : {ZERO_W, A};
    mul_b_s = sgn_s ? {{WIDTH{B[WIDTH-1]}}, B} : {ZERO_W, B};
    prod_s  = mul_a_s * mul_b_s;

    if (!MDUOp[2]) begin
      mres_s = prod_s;
    end else if (MDUOp[1]) begin
      mres_s = acc_s - prod_s;
    end else begin
      mres_s = acc_s + prod_s;
    end

    // Signed divide on magnitudes. The most-negative / -1 case falls out
    // naturally: |A| wraps to A itself and the quotient is not negated.
    abs_a_s = (sgn_s && A[WIDTH-1]) ? (~A + ONE_W) : A;
    abs_b_s = (sgn_s && B[WIDTH-1]) ? (~B + ONE_W) : B;
    div_b_s = (B == ZERO_W) ? ONE_W : abs_b_s;  // keeps the divider defined
    quo_s   = abs_a_s / div_b_s;
    rem_s   = abs_a_s % div_b_s;
    q_s     = (sgn_s && (A[WIDTH-1] ^ B[WIDTH-1])) ? (~quo_s + ONE_W) : quo_s;
    r_s     = (sgn_s && A[WIDTH-1]) ? (~rem_s + ONE_W) : rem_s;

    if (B == ZERO_W) begin
      dres_s = acc_s;
    end else begin
      dres_s = {r_s, q_s};
    end

    res_s = is_div_s ? dres_s : mres_s;
  end

  // Next-state logic: launch, count down, commit, and idle-time HI/LO moves.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    ph_s    = ph_r;
    pl_s    = pl_r;
    hi_s    = hi_r;
    lo_s    = lo_r;
    case (state_r)
      IDLE: begin
        if (Start) begin
          {ph_s, pl_s} = res_s;
          cnt_s        = is_div_s ? DIV_CNT : MUL_CNT;
          state_s      = RUN;
        end else begin
          if (HIWrite) begin
            hi_s = A;
          end else begin
            hi_s = hi_r;
          end
          if (LOWrite) begin
            lo_s = A;
          end else begin
            lo_s = lo_r;
          end
        end
      end
      RUN: begin
        if (cnt_r == {CW{1'b0}}) begin
          hi_s    = ph_r;
          lo_s    = pl_r;
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counter, pending result, HI/LO and Busy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      ph_r    <= ZERO_W;
      pl_r    <= ZERO_W;
      hi_r    <= ZERO_W;
      lo_r    <= ZERO_W;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ph_r    <= ph_s;
      pl_r    <= pl_s;
      hi_r    <= hi_s;
      lo_r    <= lo_s;
      busy_r  <= (state_s == RUN);
    end
  end

  assign Busy = busy_r;
  assign HI   = hi_r;
  assign LO   = lo_r;

  mdu_unit_chk u_chk (
    .clk     (clk),
    .reset   (reset),
    .Busy    (busy_r),
    .Start   (Start),
    .HIWrite (HIWrite),
    .LOWrite (LOWrite)
  );

endmodule
